// File: rtl/dct_block_sink.sv
// dct_block_sink: ping-pong sink between an HLS DCT core's FIFO-style
// output (Y_*) and a Xillybus 32-bit read stream (user_r_read_32_*).
// ap_clk is the Xillybus bus_clk.
module dct_block_sink #(
    parameter int BLOCK_WORDS = 64,
    parameter int CNT_W       = 16
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    input  logic [31:0]      Y_din,
    input  logic             Y_write,
    output logic             Y_full_n,
    input  logic             ap_done,
    input  logic             user_r_read_32_rden,
    output logic             user_r_read_32_empty,
    output logic [31:0]      user_r_read_32_data,
    output logic             user_r_read_32_eof,
    input  logic             user_r_read_32_open,
    output logic [CNT_W-1:0] blocks_done
);

    localparam int unsigned AW = $clog2(BLOCK_WORDS);
    localparam int unsigned LW = AW + 1;

    // Per-bank state; FILLING also means "free for the writer".
    localparam logic [1:0] BANK_FILLING  = 2'd0;
    localparam logic [1:0] BANK_READY    = 2'd1;
    localparam logic [1:0] BANK_DRAINING = 2'd2;

    logic [31:0]          mem [2*BLOCK_WORDS];

    logic [1:0][1:0]      state_q, state_d;
    logic [1:0][LW-1:0]   len_q, len_d;
    logic                 wr_bank_q, wr_bank_d;
    logic [AW-1:0]        wr_idx_q, wr_idx_d;
    logic                 rd_bank_q, rd_bank_d;
    logic [AW-1:0]        rd_idx_q, rd_idx_d;
    logic                 done_seen_q, done_seen_d;
    logic [31:0]          data_q, data_d;
    logic                 empty_q, empty_d;
    logic                 eof_q, eof_d;
    logic [CNT_W-1:0]     blocks_q, blocks_d;

    logic                 accept;
    logic                 rd_fire;
    logic                 wr_last;
    logic                 rd_last;
    logic                 commit;
    logic [LW-1:0]        commit_len;

    // Writer may push only into a free bank, while the host has the file open.
    assign Y_full_n = ap_rst_n && user_r_read_32_open &&
                      (state_q[wr_bank_q] == BANK_FILLING) && !done_seen_q;

    assign accept  = Y_write && Y_full_n;
    assign rd_fire = user_r_read_32_rden && !empty_q;
    assign wr_last = (wr_idx_q == AW'(BLOCK_WORDS - 1));
    assign rd_last = ({1'b0, rd_idx_q} == (len_q[rd_bank_q] - LW'(1)));

    assign user_r_read_32_empty = empty_q;
    assign user_r_read_32_data  = data_q;
    assign user_r_read_32_eof   = eof_q;
    assign blocks_done          = blocks_q;

    // Buffer storage; contents are don't-care after reset.
    always_ff @(posedge ap_clk) begin
        if (accept) begin
            mem[{wr_bank_q, wr_idx_q}] <= Y_din;
        end
    end

    // Control/state register with synchronous active-low reset.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state_q     <= {BANK_FILLING, BANK_FILLING};
            len_q       <= '0;
            wr_bank_q   <= 1'b0;
            wr_idx_q    <= '0;
            rd_bank_q   <= 1'b0;
            rd_idx_q    <= '0;
            done_seen_q <= 1'b0;
            data_q      <= '0;
            empty_q     <= 1'b1;
            eof_q       <= 1'b0;
            blocks_q    <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            wr_bank_q   <= wr_bank_d;
            wr_idx_q    <= wr_idx_d;
            rd_bank_q   <= rd_bank_d;
            rd_idx_q    <= rd_idx_d;
            done_seen_q <= done_seen_d;
            data_q      <= data_d;
            empty_q     <= empty_d;
            eof_q       <= eof_d;
            blocks_q    <= blocks_d;
        end
    end

    // Next-state: write/commit side, read/release side, then close and flags.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        wr_bank_d   = wr_bank_q;
        wr_idx_d    = wr_idx_q;
        rd_bank_d   = rd_bank_q;
        rd_idx_d    = rd_idx_q;
        done_seen_d = done_seen_q;
        data_d      = data_q;
        blocks_d    = blocks_q;
        commit      = 1'b0;
        commit_len  = '0;

        // A word accepted together with ap_done belongs to the final block;
        // a full block on ap_done never spawns an extra empty one.
        if (accept) begin
            wr_idx_d = wr_idx_q + AW'(1);
            if (wr_last) begin
                commit     = 1'b1;
                commit_len = LW'(BLOCK_WORDS);
            end else if (ap_done) begin
                commit     = 1'b1;
                commit_len = {1'b0, wr_idx_q} + LW'(1);
            end
        end else if (ap_done && (wr_idx_q != '0)) begin
            commit     = 1'b1;
            commit_len = {1'b0, wr_idx_q};
        end

        if (ap_done) begin
            done_seen_d = 1'b1;
        end

        if (commit) begin
            state_d[wr_bank_q] = BANK_READY;
            len_d[wr_bank_q]   = commit_len;
            wr_bank_d          = ~wr_bank_q;
            wr_idx_d           = '0;
        end

        // Commit and release always target different banks, so both apply.
        if (rd_fire) begin
            data_d = mem[{rd_bank_q, rd_idx_q}];
            if (rd_last) begin
                state_d[rd_bank_q] = BANK_FILLING;
                rd_idx_d           = '0;
                rd_bank_d          = ~rd_bank_q;
                blocks_d           = blocks_q + CNT_W'(1);
            end else begin
                state_d[rd_bank_q] = BANK_DRAINING;
                rd_idx_d           = rd_idx_q + AW'(1);
            end
        end

        // Host closing the file flushes everything except the block counter.
        if (!user_r_read_32_open) begin
            state_d     = {BANK_FILLING, BANK_FILLING};
            len_d       = '0;
            wr_bank_d   = 1'b0;
            wr_idx_d    = '0;
            rd_bank_d   = 1'b0;
            rd_idx_d    = '0;
            done_seen_d = 1'b0;
            data_d      = '0;
            blocks_d    = blocks_q;
        end

        empty_d = (state_d[rd_bank_d] == BANK_FILLING);
        eof_d   = done_seen_d && (state_d[0] == BANK_FILLING) &&
                  (state_d[1] == BANK_FILLING);
    end

endmodule

// File: tb/tb_dct_block_sink.sv
// Directed bench for dct_block_sink: written words are an incrementing
// sequence, so every read is checked against the next expected value.
module tb_dct_block_sink;

    logic        ap_clk;
    logic        ap_rst_n;
    logic [31:0] Y_din;
    logic        Y_write;
    logic        Y_full_n;
    logic        ap_done;
    logic        rden;
    logic        empty;
    logic [31:0] rdata;
    logic        eof;
    logic        open;
    logic [15:0] blocks_done;

    int checks   = 0;
    int failures = 0;
    int wr_val   = 0;   // next value to write (== words accepted so far)
    int wr_left  = 0;   // words still to push
    int exp_rd   = 0;   // next value expected on the read side
    int n_rd     = 0;   // reads completed
    int cycles   = 0;
    bit last_rd  = 1'b0;

    dct_block_sink #(.BLOCK_WORDS(64), .CNT_W(16)) dut (
        .ap_clk               (ap_clk),
        .ap_rst_n             (ap_rst_n),
        .Y_din                (Y_din),
        .Y_write              (Y_write),
        .Y_full_n             (Y_full_n),
        .ap_done              (ap_done),
        .user_r_read_32_rden  (rden),
        .user_r_read_32_empty (empty),
        .user_r_read_32_data  (rdata),
        .user_r_read_32_eof   (eof),
        .user_r_read_32_open  (open),
        .blocks_done          (blocks_done)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: present write data, note handshakes, advance, check reads.
    task automatic tick();
        logic w_fire;
        logic r_fire;
        Y_write = (wr_left > 0);
        Y_din   = 32'(wr_val);
        #1;
        w_fire = Y_write && Y_full_n;
        r_fire = rden && !empty;
        @(posedge ap_clk);
        #1;
        cycles++;
        last_rd = r_fire;
        if (w_fire) begin
            wr_val++;
            wr_left--;
        end
        Y_write = (wr_left > 0);
        Y_din   = 32'(wr_val);
        if (r_fire) begin
            check("rd_data", rdata, 32'(exp_rd));
            exp_rd++;
            n_rd++;
        end
    endtask

    task automatic run_writes(input int target, input int budget);
        int g = 0;
        while (wr_val < target && g < budget) begin
            tick();
            g++;
        end
        check("write_progress", 32'(wr_val), 32'(target));
    endtask

    task automatic run_reads(input int target, input int budget);
        int g = 0;
        while (n_rd < target && g < budget) begin
            tick();
            g++;
        end
        check("read_progress", 32'(n_rd), 32'(target));
    endtask

    initial begin
        int base;
        int c0;
        int gaps;
        int wsnap;

        ap_rst_n = 1'b0;
        open     = 1'b1;
        ap_done  = 1'b0;
        rden     = 1'b0;
        Y_write  = 1'b0;
        Y_din    = '0;

        // Reset state
        tick();
        tick();
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_eof", 32'(eof), 32'd0);
        check("rst_data", rdata, 32'd0);
        check("rst_blocks", 32'(blocks_done), 32'd0);
        check("rst_full_n", 32'(Y_full_n), 32'd0);
        ap_rst_n = 1'b1;
        #1;
        check("post_rst_full_n", 32'(Y_full_n), 32'd1);

        // One full block, rden held: empty falls right after word 63
        rden    = 1'b1;
        wr_left = 64;
        run_writes(63, 200);
        check("t1_empty_before", 32'(empty), 32'd1);
        tick();
        check("t1_w63", 32'(wr_val), 32'd64);
        check("t1_empty_after", 32'(empty), 32'd0);
        run_reads(64, 200);
        check("t1_blocks", 32'(blocks_done), 32'd1);
        check("t1_empty_end", 32'(empty), 32'd1);
        check("t1_eof", 32'(eof), 32'd0);

        // 192 writes with no reader: stall after two blocks, lift after 64 reads
        rden    = 1'b0;
        wr_left = 192;
        run_writes(192, 400);
        check("t2_full_n_low", 32'(Y_full_n), 32'd0);
        repeat (5) tick();
        check("t2_stalled", 32'(wr_val), 32'd192);
        check("t2_empty", 32'(empty), 32'd0);
        rden = 1'b1;
        run_reads(127, 200);
        check("t2_still_full", 32'(Y_full_n), 32'd0);
        tick();
        check("t2_read64", 32'(n_rd), 32'd128);
        check("t2_full_n_lift", 32'(Y_full_n), 32'd1);
        check("t2_no_early_write", 32'(wr_val), 32'd192);
        run_reads(256, 600);
        check("t2_all_written", 32'(wr_val), 32'd256);
        check("t2_blocks", 32'(blocks_done), 32'd4);

        // 70 words then ap_done: full block + 6-word tail, then eof
        rden    = 1'b0;
        wr_left = 70;
        run_writes(326, 300);
        ap_done = 1'b1;
        tick();
        ap_done = 1'b0;
        check("t3_eof_early", 32'(eof), 32'd0);
        check("t3_empty", 32'(empty), 32'd0);
        check("t3_full_n", 32'(Y_full_n), 32'd0);
        rden = 1'b1;
        run_reads(320, 200);
        check("t3_blocks_mid", 32'(blocks_done), 32'd5);
        run_reads(325, 50);
        check("t3_eof_before_last", 32'(eof), 32'd0);
        run_reads(326, 50);
        check("t3_eof", 32'(eof), 32'd1);
        check("t3_empty_end", 32'(empty), 32'd1);
        check("t3_blocks", 32'(blocks_done), 32'd6);
        tick();
        check("t3_eof_held", 32'(eof), 32'd1);

        // Reset clears eof; reset mid-block discards 30 buffered words
        rden     = 1'b0;
        ap_rst_n = 1'b0;
        tick();
        ap_rst_n = 1'b1;
        check("t4_eof_cleared", 32'(eof), 32'd0);
        wr_left = 30;
        run_writes(356, 100);
        check("t4_empty_partial", 32'(empty), 32'd1);
        ap_rst_n = 1'b0;
        tick();
        check("t4_rst_empty", 32'(empty), 32'd1);
        check("t4_rst_eof", 32'(eof), 32'd0);
        check("t4_rst_blocks", 32'(blocks_done), 32'd0);
        check("t4_rst_full_n", 32'(Y_full_n), 32'd0);
        ap_rst_n = 1'b1;
        exp_rd   = wr_val;
        base     = n_rd;
        wr_left  = 64;
        rden     = 1'b1;
        run_reads(base + 64, 300);
        check("t4_blocks", 32'(blocks_done), 32'd1);

        // Streaming: commit and release coincide, no bubble and no stall
        base    = n_rd;
        c0      = cycles;
        gaps    = 0;
        wr_left = 256;
        begin
            int g = 0;
            while (n_rd < base + 256 && g < 800) begin
                tick();
                g++;
                if (n_rd > base && n_rd < base + 256 && !last_rd) gaps++;
            end
        end
        check("t5_reads", 32'(n_rd - base), 32'd256);
        check("t5_gaps", 32'(gaps), 32'd0);
        check("t5_cycles", 32'(cycles - c0), 32'd320);
        check("t5_blocks", 32'(blocks_done), 32'd5);

        // Close with one READY bank: flushed, counter kept, writer held off
        rden    = 1'b0;
        wr_left = 64;
        run_writes(wr_val + 64, 200);
        check("t6_empty_ready", 32'(empty), 32'd0);
        check("t6_full_n_open", 32'(Y_full_n), 32'd1);
        open = 1'b0;
        tick();
        check("t6_empty", 32'(empty), 32'd1);
        check("t6_blocks", 32'(blocks_done), 32'd5);
        check("t6_full_n_closed", 32'(Y_full_n), 32'd0);
        check("t6_eof", 32'(eof), 32'd0);
        wsnap   = wr_val;
        wr_left = 3;
        rden    = 1'b1;
        tick();
        tick();
        check("t6_write_ignored", 32'(wr_val), 32'(wsnap));
        check("t6_read_ignored", 32'(rdata), 32'd0);
        wr_left = 0;
        rden    = 1'b0;
        open    = 1'b1;
        #1;
        check("t6_full_n_reopen", 32'(Y_full_n), 32'd1);
        exp_rd  = wr_val;
        base    = n_rd;
        wr_left = 64;
        rden    = 1'b1;
        run_reads(base + 64, 300);
        check("t6_blocks_after", 32'(blocks_done), 32'd6);

        // ap_done on the cycle word 63 lands: one full block, no empty block
        rden    = 1'b0;
        wsnap   = wr_val;
        wr_left = 64;
        run_writes(wsnap + 63, 200);
        ap_done = 1'b1;
        tick();
        ap_done = 1'b0;
        check("t7_w63", 32'(wr_val), 32'(wsnap + 64));
        check("t7_empty", 32'(empty), 32'd0);
        check("t7_eof_early", 32'(eof), 32'd0);
        base = n_rd;
        rden = 1'b1;
        run_reads(base + 64, 200);
        check("t7_eof", 32'(eof), 32'd1);
        check("t7_empty_end", 32'(empty), 32'd1);
        check("t7_blocks", 32'(blocks_done), 32'd7);
        repeat (3) tick();
        check("t7_no_extra_read", 32'(n_rd - base), 32'd64);
        check("t7_eof_held", 32'(eof), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global guard so the run always terminates.
    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
